// File: rtl/robot_cmd_pkg.sv
// Shared command codes, button bit positions and decode helpers for the button command scheduler.
package robot_cmd_pkg;

   localparam int unsigned NUM_BUTTONS = 11;

   typedef logic [2:0] cmd_t;

   localparam cmd_t CMD_NONE  = 3'd0;
   localparam cmd_t CMD_UP    = 3'd1;
   localparam cmd_t CMD_DOWN  = 3'd2;
   localparam cmd_t CMD_LEFT  = 3'd3;
   localparam cmd_t CMD_RIGHT = 3'd4;
   localparam cmd_t CMD_CLEAN = 3'd5;
   localparam cmd_t CMD_PAUSE = 3'd6;

   localparam int unsigned BTN_UP    = 0;
   localparam int unsigned BTN_DOWN  = 1;
   localparam int unsigned BTN_LEFT  = 2;
   localparam int unsigned BTN_RIGHT = 3;
   localparam int unsigned BTN_A     = 4;
   localparam int unsigned BTN_B     = 5;
   localparam int unsigned BTN_C     = 6;
   localparam int unsigned BTN_X     = 7;
   localparam int unsigned BTN_Y     = 8;
   localparam int unsigned BTN_Z     = 9;
   localparam int unsigned BTN_START = 10;

   typedef enum logic {
      StRun,
      StPaused
   } state_t;

   // Opposing directions held together cancel each other out.
   function automatic logic [3:0] mask_conflicts(input logic [3:0] dirs);
      logic [3:0] m;
      m = dirs;
      if (dirs[0] && dirs[1]) m[1:0] = 2'b00;
      if (dirs[2] && dirs[3]) m[3:2] = 2'b00;
      return m;
   endfunction

   // Highest-priority direction: up > down > left > right.
   function automatic cmd_t dir_of(input logic [3:0] dirs);
      if (dirs[0])      return CMD_UP;
      else if (dirs[1]) return CMD_DOWN;
      else if (dirs[2]) return CMD_LEFT;
      else if (dirs[3]) return CMD_RIGHT;
      else              return CMD_NONE;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with synchronous active-low reset; a push while full is accepted only
// when a pop happens in the same cycle.
module cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == (AW+1)'(DEPTH));
   assign pop_data = mem_q[rd_ptr_q];
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/button_cmd_scheduler.sv
// Turns per-frame button snapshots into queued robot commands with priority, pause filtering
// and, when CMD_AUTOREPEAT_EN is defined, auto-repeat of a held direction.
module button_cmd_scheduler
   import robot_cmd_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned REPEAT_DELAY  = 20,
   parameter int unsigned REPEAT_PERIOD = 6
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_BUTTONS-1:0] buttons_in,
   input  logic                   buttons_valid,
   output logic                   cmd_valid,
   output logic [2:0]             cmd_code,
   input  logic                   cmd_ready,
   output logic                   paused,
   output logic                   overflow
);

   state_t                 state_q, state_d;
   logic [NUM_BUTTONS-1:0] prev_q;
   logic                   primed_q;
   logic                   overflow_q, overflow_d;

   logic [3:0] dirs_now, press_dirs;
   logic       start_press, a_press, frame_live;
   cmd_t       cmd, repeat_cmd, head;
   logic       push, pop, full, empty;

   logic unused_btns;
   assign unused_btns = ^{buttons_in[BTN_Z:BTN_B], prev_q[BTN_Z:BTN_B]};

   assign dirs_now   = mask_conflicts(buttons_in[BTN_RIGHT:BTN_UP]);
   assign frame_live = buttons_valid & primed_q;

`ifdef CMD_AUTOREPEAT_EN
   localparam logic [7:0] DELAY8  = 8'(REPEAT_DELAY);
   localparam logic [7:0] PERIOD8 = 8'(REPEAT_PERIOD);

   logic [7:0] hold_q, hold_d, period_q, period_d;
   cmd_t       held_now, held_prev;
   logic       rpt;

   assign held_now  = dir_of(dirs_now);
   assign held_prev = dir_of(mask_conflicts(prev_q[BTN_RIGHT:BTN_UP]));

   always_comb begin
      hold_d   = hold_q;
      period_d = period_q;
      rpt      = 1'b0;
      if (frame_live) begin
         if (state_q == StPaused || held_now == CMD_NONE || held_now != held_prev) begin
            hold_d   = '0;
            period_d = '0;
         end else begin
            hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
            // Past the first repeat the period counter alone paces repeats, so saturation is harmless.
            if (hold_q >= DELAY8) begin
               period_d = period_q + 8'd1;
               if (period_d == PERIOD8) begin
                  rpt      = 1'b1;
                  period_d = '0;
               end
            end else if (hold_d == DELAY8) begin
               rpt      = 1'b1;
               period_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_q   <= '0;
         period_q <= '0;
      end else begin
         hold_q   <= hold_d;
         period_q <= period_d;
      end
   end

   assign repeat_cmd = rpt ? held_now : CMD_NONE;
`else
   logic unused_cfg;
   assign unused_cfg = ^{REPEAT_DELAY[7:0], REPEAT_PERIOD[7:0]};
   assign repeat_cmd = CMD_NONE;
`endif

   always_comb begin
      press_dirs  = dirs_now & ~prev_q[BTN_RIGHT:BTN_UP];
      start_press = buttons_in[BTN_START] & ~prev_q[BTN_START];
      a_press     = buttons_in[BTN_A] & ~prev_q[BTN_A];
      cmd         = CMD_NONE;
      if (start_press) begin
         cmd = CMD_PAUSE;
      end else if (state_q == StRun) begin
         if (a_press) cmd = CMD_CLEAN;
         else         cmd = dir_of(press_dirs);
         if (cmd == CMD_NONE) cmd = repeat_cmd;
      end
      push = frame_live & (cmd != CMD_NONE);

      // The state flips even when the PAUSE entry itself is dropped on a full queue.
      state_d = state_q;
      if (frame_live && start_press) state_d = (state_q == StRun) ? StPaused : StRun;

      overflow_d = overflow_q | (push & full & ~pop);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StRun;
         prev_q     <= '0;
         primed_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         overflow_q <= overflow_d;
         if (buttons_valid) begin
            prev_q   <= buttons_in;
            primed_q <= 1'b1;
         end
      end
   end

   cmd_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(3)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_data(cmd),
      .pop      (pop),
      .pop_data (head),
      .full     (full),
      .empty    (empty)
   );

   assign cmd_valid = ~empty;
   assign pop       = cmd_valid & cmd_ready;
   assign cmd_code  = empty ? CMD_NONE : head;
   assign paused    = (state_q == StPaused);
   assign overflow  = overflow_q;

endmodule
